npu_scheduler: RTL and testbench

Microcode sequencer for the NPU datapath. A host loads a program of 16-bit control words while the NPU is idle. During compute the block replays the program cycle by cycle, decoding each word into FIFO enables, PE selects and sigmoid-unit controls. The program loops continuously until compute is deasserted.

---
 rtl/npu_scheduler_if.sv | 52 +++++
 rtl/npu_scheduler.sv | 80 ++++++++
 tb/tb_npu_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_scheduler_if.sv
// Host/NPU bundle for the microcode sequencer:
// program-load inputs, compute enable and decoded controls.
interface npu_scheduler_if;
  logic        npu_sched_write_en;
  logic [15:0] npu_sched_din;
  logic        npu_state_compute;
  logic        npu_sched_input_fifo_read_en;
  logic        npu_sched_sigmoid_fifo_read_en;
  logic        npu_sched_sigmoid_fifo_write_en;
  logic        npu_sched_output_fifo_write_en;
  logic [2:0]  npu_sched_pe_select_in;
  logic        npu_sched_pe_write_en;
  logic        npu_sched_acc_fifo_read_en;
  logic        npu_sched_acc_fifo_write_en;
  logic [2:0]  npu_sched_sigmoid_input_sel_pe;
  logic        npu_sched_sigmoid_input_en;
  logic [1:0]  npu_sched_sigmoid_function_sel;

  modport master (
    output npu_sched_write_en,
    output npu_sched_din,
    output npu_state_compute,
    input  npu_sched_input_fifo_read_en,
    input  npu_sched_sigmoid_fifo_read_en,
    input  npu_sched_sigmoid_fifo_write_en,
    input  npu_sched_output_fifo_write_en,
    input  npu_sched_pe_select_in,
    input  npu_sched_pe_write_en,
    input  npu_sched_acc_fifo_read_en,
    input  npu_sched_acc_fifo_write_en,
    input  npu_sched_sigmoid_input_sel_pe,
    input  npu_sched_sigmoid_input_en,
    input  npu_sched_sigmoid_function_sel
  );

  modport slave (
    input  npu_sched_write_en,
    input  npu_sched_din,
    input  npu_state_compute,
    output npu_sched_input_fifo_read_en,
    output npu_sched_sigmoid_fifo_read_en,
    output npu_sched_sigmoid_fifo_write_en,
    output npu_sched_output_fifo_write_en,
    output npu_sched_pe_select_in,
    output npu_sched_pe_write_en,
    output npu_sched_acc_fifo_read_en,
    output npu_sched_acc_fifo_write_en,
    output npu_sched_sigmoid_input_sel_pe,
    output npu_sched_sigmoid_input_en,
    output npu_sched_sigmoid_function_sel
  );
endinterface

// File: rtl/npu_scheduler.sv
// NPU microcode sequencer: loads control words while idle,
// replays them in a loop while compute is high.
module npu_scheduler #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic            CLK,
  input  logic            npu_rst,
  npu_scheduler_if.slave  bus
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [15:0]       ctrl_q, ctrl_d;
  logic              wr_ok;
  logic              run;
  logic              last;

  always_comb begin
    wr_ok = bus.npu_sched_write_en
          && !bus.npu_state_compute
          && (len_q != FULL);
    run   = bus.npu_state_compute
          && (len_q != '0);
    last  = ({1'b0, rd_ptr_q} == len_q - 1'b1);

    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    rd_ptr_d = '0;
    ctrl_d   = '0;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      len_d    = len_q + 1'b1;
    end

    if (run) begin
      ctrl_d   = mem[rd_ptr_q];
      rd_ptr_d = last ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Program storage is never cleared; len_q gates reachability.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= bus.npu_sched_din;
    end
  end

  always_ff @(posedge CLK or negedge npu_rst) begin
    if (!npu_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      ctrl_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign bus.npu_sched_input_fifo_read_en    = ctrl_q[0];
  assign bus.npu_sched_sigmoid_fifo_read_en  = ctrl_q[1];
  assign bus.npu_sched_sigmoid_fifo_write_en = ctrl_q[2];
  assign bus.npu_sched_output_fifo_write_en  = ctrl_q[3];
  assign bus.npu_sched_pe_select_in          = ctrl_q[6:4];
  assign bus.npu_sched_pe_write_en           = ctrl_q[7];
  assign bus.npu_sched_acc_fifo_read_en      = ctrl_q[8];
  assign bus.npu_sched_acc_fifo_write_en     = ctrl_q[9];
  assign bus.npu_sched_sigmoid_input_sel_pe  = ctrl_q[12:10];
  assign bus.npu_sched_sigmoid_input_en      = ctrl_q[13];
  assign bus.npu_sched_sigmoid_function_sel  = ctrl_q[15:14];

endmodule

// File: tb/tb_npu_scheduler.sv
// Scoreboard bench for npu_scheduler: program words are
// queued as expected outputs and popped every compute cycle.
module tb_npu_scheduler;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [15:0] prog[$];
  logic [15:0] sb[$];

  npu_scheduler_if bus ();

  npu_scheduler #(.DEPTH(64), .ADDR_W(6)) dut (
    .CLK     (clk),
    .npu_rst (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {bus.npu_sched_sigmoid_function_sel,
            bus.npu_sched_sigmoid_input_en,
            bus.npu_sched_sigmoid_input_sel_pe,
            bus.npu_sched_acc_fifo_write_en,
            bus.npu_sched_acc_fifo_read_en,
            bus.npu_sched_pe_write_en,
            bus.npu_sched_pe_select_in,
            bus.npu_sched_output_fifo_write_en,
            bus.npu_sched_sigmoid_fifo_write_en,
            bus.npu_sched_sigmoid_fifo_read_en,
            bus.npu_sched_input_fifo_read_en};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.npu_state_compute  = 1'b0;
    bus.npu_sched_write_en = 1'b0;
    bus.npu_sched_din      = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    prog.delete();
    sb.delete();
  endtask

  task automatic load(input logic [15:0] w);
    bus.npu_sched_write_en = 1'b1;
    bus.npu_sched_din      = w;
    step();
    bus.npu_sched_write_en = 1'b0;
    if (prog.size() < 64) prog.push_back(w);
  endtask

  task automatic test_reset();
    logic [15:0] o;
    bus.npu_state_compute  = 1'b0;
    bus.npu_sched_write_en = 1'b0;
    bus.npu_sched_din      = '0;
    rst_n = 1'b0;
    repeat (2) step();
    o = obs();
    n_chk++;
    if (o !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=0000", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.npu_state_compute = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      o = obs();
      n_chk++;
      if (o !== 16'h0) begin
        n_fail++;
        $display("FAIL empty_compute c%0d got=%h exp=0000", i, o);
      end
    end
    bus.npu_state_compute = 1'b0;
    step();
  endtask

  task automatic test_replay();
    logic [15:0] o, e;
    do_reset();
    load(16'hA5C3);
    for (int i = 1; i < 10; i++) load(16'($urandom));
    for (int i = 0; i < 12; i++) sb.push_back(prog[i % 10]);
    bus.npu_state_compute = 1'b1;
    step();
    n_chk++;
    if (bus.npu_sched_sigmoid_function_sel !== 2'd2 ||
        bus.npu_sched_sigmoid_input_en     !== 1'b1 ||
        bus.npu_sched_sigmoid_input_sel_pe !== 3'd1 ||
        bus.npu_sched_acc_fifo_write_en    !== 1'b0 ||
        bus.npu_sched_acc_fifo_read_en     !== 1'b1 ||
        bus.npu_sched_pe_write_en          !== 1'b1 ||
        bus.npu_sched_pe_select_in         !== 3'd4 ||
        bus.npu_sched_output_fifo_write_en !== 1'b0 ||
        bus.npu_sched_sigmoid_fifo_write_en !== 1'b0 ||
        bus.npu_sched_sigmoid_fifo_read_en !== 1'b1 ||
        bus.npu_sched_input_fifo_read_en   !== 1'b1) begin
      n_fail++;
      $display("FAIL a5c3_fields got=%h exp=a5c3", obs());
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      o = obs();
      e = sb.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL replay c%0d got=%h exp=%h", i, o, e);
      end
    end
    bus.npu_state_compute = 1'b0;
    step();
  endtask

  task automatic test_write_in_compute();
    logic [15:0] o, e;
    for (int i = 0; i < 25; i++) sb.push_back(prog[i % 10]);
    bus.npu_state_compute  = 1'b1;
    bus.npu_sched_write_en = 1'b1;
    bus.npu_sched_din      = 16'hFFFF;
    while (sb.size() > 0) begin
      step();
      o = obs();
      e = sb.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wr_in_compute got=%h exp=%h", o, e);
      end
    end
    bus.npu_sched_write_en = 1'b0;
    bus.npu_state_compute  = 1'b0;
    step();
    o = obs();
    n_chk++;
    if (o !== 16'h0) begin
      n_fail++;
      $display("FAIL idle_after_wr got=%h exp=0000", o);
    end
    for (int i = 0; i < 10; i++) sb.push_back(prog[i]);
    bus.npu_state_compute = 1'b1;
    while (sb.size() > 0) begin
      step();
      o = obs();
      e = sb.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL prog_intact got=%h exp=%h", o, e);
      end
    end
    bus.npu_state_compute = 1'b0;
    step();
  endtask

  task automatic test_idle_restart();
    logic [15:0] o, e;
    for (int i = 0; i < 4; i++) sb.push_back(prog[i]);
    for (int i = 0; i < 3; i++) sb.push_back(16'h0);
    for (int i = 0; i < 5; i++) sb.push_back(prog[i]);
    bus.npu_state_compute = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 3) bus.npu_state_compute = 1'b0;
      if (c == 6) bus.npu_state_compute = 1'b1;
      o = obs();
      e = sb.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle_restart c%0d got=%h exp=%h", c, o, e);
      end
    end
    bus.npu_state_compute = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] o;
    bus.npu_state_compute = 1'b1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    o = obs();
    n_chk++;
    if (o !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0000", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      o = obs();
      n_chk++;
      if (o !== 16'h0) begin
        n_fail++;
        $display("FAIL discarded c%0d got=%h exp=0000", i, o);
      end
    end
    bus.npu_state_compute = 1'b0;
    step();
    prog.delete();
  endtask

  task automatic test_overflow();
    logic [15:0] o, e;
    do_reset();
    for (int i = 0; i < 64; i++) load(16'h1000 | 16'(i));
    load(16'hBEEF);
    for (int i = 0; i < 130; i++) sb.push_back(prog[i % 64]);
    bus.npu_state_compute = 1'b1;
    for (int c = 0; c < 130; c++) begin
      step();
      o = obs();
      e = sb.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL overflow c%0d got=%h exp=%h", c, o, e);
      end
    end
    bus.npu_state_compute = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [15:0] o;
    do_reset();
    load(16'h0081);
    for (int i = 0; i < 5; i++) sb.push_back(prog[0]);
    bus.npu_state_compute = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      o = obs();
      n_chk++;
      if (o !== sb.pop_front() ||
          bus.npu_sched_input_fifo_read_en !== 1'b1 ||
          bus.npu_sched_pe_write_en !== 1'b1) begin
        n_fail++;
        $display("FAIL single c%0d got=%h exp=0081", c, o);
      end
    end
    bus.npu_state_compute = 1'b0;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    test_reset();
    test_replay();
    test_write_in_compute();
    test_idle_restart();
    test_reset_mid();
    test_overflow();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
